// File: rtl/aud_dac_player_if.sv
// Sample handshake between the upstream PCM source and aud_dac_player.
interface aud_dac_player_if #(
    parameter int DATA_W = 16
) ();
    logic              i_sample_valid;
    logic [DATA_W-1:0] i_sample;
    logic              o_sample_ready;

    modport master (output i_sample_valid, output i_sample, input o_sample_ready);
    modport slave  (input i_sample_valid, input i_sample, output o_sample_ready);
endinterface

// File: rtl/aud_dac_player.sv
// I2S playback: FIFO-buffered PCM samples shifted MSB-first onto DACDAT in the left slot.
// Optional AUD_STEREO_DUP_EN repeats each popped sample in the right slot.
module aud_dac_player #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_daclrc,
    input  logic                          i_en,
    input  logic                          i_flush,
    aud_dac_player_if.slave               smp,
    output logic                          o_aud_dacdat,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_underflow,
    output logic [CNT_W-1:0]              o_underflow_cnt
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int BC_W  = $clog2(DATA_W);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              lrc_prev_q, lrc_prev_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
    logic              dacdat_q, dacdat_d;
    logic              underflow_q, underflow_d;
    logic [CNT_W-1:0]  ucnt_q, ucnt_d;
`ifdef AUD_STEREO_DUP_EN
    logic [DATA_W-1:0] held_q, held_d;
    logic              held_vld_q, held_vld_d;
`endif

    logic              fifo_empty, ready, push, pop, left_edge, right_edge;
    logic [DATA_W-1:0] head;

    assign fifo_empty = (level_q == '0);
    assign ready      = (level_q != FULL_LVL);
    assign push       = smp.i_sample_valid & ready & ~i_flush;
    assign head       = mem_q[rd_ptr_q];
    assign left_edge  = lrc_prev_q & ~i_daclrc;
    assign right_edge = ~lrc_prev_q & i_daclrc;
    assign lrc_prev_d = i_daclrc;

    // Flush wins over push/pop pointer updates; a pop in the flush cycle still hands the head to the shifter.
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = smp.i_sample;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        dacdat_d    = 1'b0;
        underflow_d = 1'b0;
        ucnt_d      = ucnt_q;
        pop         = 1'b0;
`ifdef AUD_STEREO_DUP_EN
        held_d      = held_q;
        held_vld_d  = held_vld_q;
`endif
        if (!i_en) begin
            state_d = S_IDLE;
`ifdef AUD_STEREO_DUP_EN
            held_vld_d = 1'b0;
`endif
        end else if (state_q == S_IDLE) begin
            state_d = S_WAIT;
        end else begin
            if (state_q == S_SHIFT) begin
                if (bitcnt_q != '0) begin
                    dacdat_d = shreg_q[DATA_W-1];
                    shreg_d  = shreg_q << 1;
                    bitcnt_d = bitcnt_q - 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            // A frame edge overrides any word still shifting (short frame restart).
            if (left_edge) begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    dacdat_d = head[DATA_W-1];
                    shreg_d  = head << 1;
                    bitcnt_d = LAST_BIT;
                    state_d  = S_SHIFT;
`ifdef AUD_STEREO_DUP_EN
                    held_d     = head;
                    held_vld_d = 1'b1;
`endif
                end else begin
                    underflow_d = 1'b1;
                    if (ucnt_q != '1) ucnt_d = ucnt_q + 1'b1;
                    dacdat_d = 1'b0;
                    state_d  = S_WAIT;
`ifdef AUD_STEREO_DUP_EN
                    held_vld_d = 1'b0;
`endif
                end
            end
`ifdef AUD_STEREO_DUP_EN
            else if (right_edge) begin
                if (held_vld_q) begin
                    dacdat_d   = held_q[DATA_W-1];
                    shreg_d    = held_q << 1;
                    bitcnt_d   = LAST_BIT;
                    state_d    = S_SHIFT;
                    held_vld_d = 1'b0;
                end else begin
                    dacdat_d = 1'b0;
                    state_d  = S_WAIT;
                end
            end
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            lrc_prev_q  <= 1'b1;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            dacdat_q    <= 1'b0;
            underflow_q <= 1'b0;
            ucnt_q      <= '0;
`ifdef AUD_STEREO_DUP_EN
            held_q      <= '0;
            held_vld_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            lrc_prev_q  <= lrc_prev_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            dacdat_q    <= dacdat_d;
            underflow_q <= underflow_d;
            ucnt_q      <= ucnt_d;
`ifdef AUD_STEREO_DUP_EN
            held_q      <= held_d;
            held_vld_q  <= held_vld_d;
`endif
        end
    end

    assign smp.o_sample_ready = ready;
    assign o_aud_dacdat       = dacdat_q;
    assign o_fifo_level       = level_q;
    assign o_underflow        = underflow_q;
    assign o_underflow_cnt    = ucnt_q;
endmodule

// File: tb/tb_aud_dac_player.sv
// Directed bench for aud_dac_player; inputs change and outputs are sampled on the falling BCLK edge.
module tb_aud_dac_player;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       lrc, en, flush;
    logic       dacdat, underflow;
    logic [2:0] level;
    logic [7:0] ucnt;
    int         vectors = 0;
    int         miscompares = 0;

    aud_dac_player_if #(.DATA_W(16)) smp ();

    aud_dac_player #(.DATA_W(16), .FIFO_DEPTH(4), .CNT_W(8)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_daclrc        (lrc),
        .i_en            (en),
        .i_flush         (flush),
        .smp             (smp),
        .o_aud_dacdat    (dacdat),
        .o_fifo_level    (level),
        .o_underflow     (underflow),
        .o_underflow_cnt (ucnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        lrc = 1'b1;
        en = 1'b0;
        flush = 1'b0;
        smp.i_sample_valid = 1'b0;
        smp.i_sample = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push(input logic [15:0] w);
        smp.i_sample_valid = 1'b1;
        smp.i_sample = w;
        tick();
        smp.i_sample_valid = 1'b0;
    endtask

    // Caller has just driven the LRC edge; checks 16 data bits then the trailing zero.
    task automatic check_frame(input logic [15:0] w, input string name);
        for (int i = 15; i >= 0; i--) begin
            tick();
            vectors++;
            if (dacdat !== w[i]) begin
                miscompares++;
                $display("FAIL %s bit%0d: got %b want %b", name, i, dacdat, w[i]);
            end
        end
        tick();
        vectors++;
        if (dacdat !== 1'b0) begin
            miscompares++;
            $display("FAIL %s tail: got %b want 0", name, dacdat);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors += 5;
        if (dacdat !== 1'b0)             begin miscompares++; $display("FAIL reset_dacdat: got %b want 0", dacdat); end
        if (smp.o_sample_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", smp.o_sample_ready); end
        if (level !== 3'd0)              begin miscompares++; $display("FAIL reset_level: got %0d want 0", level); end
        if (underflow !== 1'b0)          begin miscompares++; $display("FAIL reset_underflow: got %b want 0", underflow); end
        if (ucnt !== 8'd0)               begin miscompares++; $display("FAIL reset_cnt: got %0d want 0", ucnt); end
    endtask

    task automatic test_basic_frame();
        do_reset();
        en = 1'b1;
        tick();
        push(16'hA5C3);
        vectors++;
        if (level !== 3'd1) begin miscompares++; $display("FAIL basic_level_pre: got %0d want 1", level); end
        lrc = 1'b0;
        check_frame(16'hA5C3, "basic");
        vectors += 2;
        if (level !== 3'd0)     begin miscompares++; $display("FAIL basic_level_post: got %0d want 0", level); end
        if (underflow !== 1'b0) begin miscompares++; $display("FAIL basic_underflow: got %b want 0", underflow); end
    endtask

    task automatic test_underflow();
        do_reset();
        en = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            lrc = 1'b0;
            tick();
            vectors += 2;
            if (underflow !== 1'b1) begin miscompares++; $display("FAIL uf_pulse%0d: got %b want 1", k, underflow); end
            if (dacdat !== 1'b0)    begin miscompares++; $display("FAIL uf_dacdat%0d: got %b want 0", k, dacdat); end
            lrc = 1'b1;
            tick();
            vectors++;
            if (underflow !== 1'b0) begin miscompares++; $display("FAIL uf_clear%0d: got %b want 0", k, underflow); end
        end
        vectors++;
        if (ucnt !== 8'd3) begin miscompares++; $display("FAIL uf_cnt: got %0d want 3", ucnt); end
    endtask

    task automatic test_fill();
        do_reset();
        en = 1'b1;
        smp.i_sample_valid = 1'b1;
        smp.i_sample = 16'hC0DE;
        repeat (6) tick();
        vectors += 2;
        if (level !== 3'd4)              begin miscompares++; $display("FAIL fill_level: got %0d want 4", level); end
        if (smp.o_sample_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready: got %b want 0", smp.o_sample_ready); end
        lrc = 1'b0;
        tick();
        smp.i_sample_valid = 1'b0;
        vectors += 3;
        if (level !== 3'd3)              begin miscompares++; $display("FAIL fill_level_pop: got %0d want 3", level); end
        if (smp.o_sample_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready_pop: got %b want 1", smp.o_sample_ready); end
        if (dacdat !== 1'b1)             begin miscompares++; $display("FAIL fill_msb: got %b want 1", dacdat); end
        repeat (17) tick();
    endtask

    task automatic test_abort();
        do_reset();
        en = 1'b1;
        tick();
        push(16'hFFFF);
        push(16'h0F0F);
        lrc = 1'b0;
        repeat (9) tick();
        vectors++;
        if (dacdat !== 1'b1) begin miscompares++; $display("FAIL abort_bit7: got %b want 1", dacdat); end
        en = 1'b0;
        tick();
        vectors += 2;
        if (dacdat !== 1'b0) begin miscompares++; $display("FAIL abort_dacdat: got %b want 0", dacdat); end
        if (level !== 3'd1)  begin miscompares++; $display("FAIL abort_level: got %0d want 1", level); end
        lrc = 1'b1;
        tick();
        lrc = 1'b0;
        tick();
        tick();
        vectors += 3;
        if (dacdat !== 1'b0)    begin miscompares++; $display("FAIL idle_dacdat: got %b want 0", dacdat); end
        if (underflow !== 1'b0) begin miscompares++; $display("FAIL idle_underflow: got %b want 0", underflow); end
        if (level !== 3'd1)     begin miscompares++; $display("FAIL idle_level: got %0d want 1", level); end
    endtask

    task automatic test_saturate();
        do_reset();
        en = 1'b1;
        tick();
        for (int k = 0; k < 255; k++) begin
            lrc = 1'b0;
            tick();
            lrc = 1'b1;
            tick();
        end
        vectors++;
        if (ucnt !== 8'hFF) begin miscompares++; $display("FAIL sat_cnt255: got %h want ff", ucnt); end
        lrc = 1'b0;
        tick();
        vectors += 2;
        if (underflow !== 1'b1) begin miscompares++; $display("FAIL sat_pulse: got %b want 1", underflow); end
        if (ucnt !== 8'hFF)     begin miscompares++; $display("FAIL sat_cnt: got %h want ff", ucnt); end
        lrc = 1'b1;
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        en = 1'b1;
        tick();
        push(16'h1234);
        push(16'h5678);
        flush = 1'b1;
        smp.i_sample_valid = 1'b1;
        smp.i_sample = 16'h9ABC;
        tick();
        flush = 1'b0;
        smp.i_sample_valid = 1'b0;
        vectors += 2;
        if (level !== 3'd0)              begin miscompares++; $display("FAIL flush_level: got %0d want 0", level); end
        if (smp.o_sample_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready: got %b want 1", smp.o_sample_ready); end
        lrc = 1'b0;
        tick();
        vectors++;
        if (underflow !== 1'b1) begin miscompares++; $display("FAIL flush_underflow: got %b want 1", underflow); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        en = 1'b1;
        tick();
        push(16'h8000);
        push(16'h0001);
        lrc = 1'b0;
        smp.i_sample_valid = 1'b1;
        smp.i_sample = 16'h7FFF;
        tick();
        smp.i_sample_valid = 1'b0;
        vectors += 2;
        if (level !== 3'd2)  begin miscompares++; $display("FAIL b2b_level: got %0d want 2", level); end
        if (dacdat !== 1'b1) begin miscompares++; $display("FAIL b2b_msb: got %b want 1", dacdat); end
        repeat (17) tick();
        lrc = 1'b1;
        tick();
        // Short frame: second word starts, then a new left edge mid-word restarts with the third.
        lrc = 1'b0;
        repeat (4) tick();
        lrc = 1'b1;
        tick();
        lrc = 1'b0;
        check_frame(16'h7FFF, "restart");
        vectors++;
        if (level !== 3'd0) begin miscompares++; $display("FAIL restart_level: got %0d want 0", level); end
    endtask

    task automatic test_stereo();
        logic [15:0] right_exp;
`ifdef AUD_STEREO_DUP_EN
        right_exp = 16'h8001;
`else
        right_exp = 16'h0000;
`endif
        do_reset();
        en = 1'b1;
        tick();
        push(16'h8001);
        lrc = 1'b0;
        check_frame(16'h8001, "left");
        lrc = 1'b1;
        check_frame(right_exp, "right");
        vectors++;
        if (level !== 3'd0) begin miscompares++; $display("FAIL stereo_level: got %0d want 0", level); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_underflow();
        test_fill();
        test_abort();
        test_saturate();
        test_flush();
        test_back_to_back();
        test_stereo();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
